// File: rtl/sm83_bus_ctl.sv
// External memory-bus sequencer: runs the 4-T-state M-cycle, drives address/data/strobe
// pins from registered state, and returns captured read data to the core.
module sm83_bus_ctl #(
  parameter int ADR_W  = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADR_W-1:0]  apin,
  input  logic [DATA_W-1:0] dout,
  input  logic              ctl_mread,
  input  logic              ctl_mwrite,
  input  logic              ctl_hold,
  input  logic [DATA_W-1:0] d_pin_in,
  output logic [ADR_W-1:0]  a_pin,
  output logic [DATA_W-1:0] d_pin_out,
  output logic              d_pin_oe,
  output logic              rd_n,
  output logic              wr_n,
  output logic [DATA_W-1:0] din,
  output logic              din_valid,
  output logic [1:0]        t_phase,
  output logic              m_start,
  output logic              m_end,
  output logic              req_err
);

  typedef enum logic [2:0] {
    ST_T1   = 3'd0,
    ST_T2   = 3'd1,
    ST_T3   = 3'd2,
    ST_T4   = 3'd3,
    ST_HOLD = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    CYC_NONE  = 2'd0,
    CYC_READ  = 2'd1,
    CYC_WRITE = 2'd2
  } cyc_t;

  state_t state_reg, state_next;
  cyc_t   cyc_reg, cyc_next;
  logic   enter_t1;
  logic   rd_n_next, wr_n_next, oe_next, din_valid_next;
  logic   m_start_next, m_end_next;
  logic [1:0] t_phase_next;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_T1:   state_next = ST_T2;
      ST_T2:   state_next = ST_T3;
      ST_T3:   state_next = ST_T4;
      ST_T4:   state_next = ctl_hold ? ST_HOLD : ST_T1;
      ST_HOLD: state_next = ctl_hold ? ST_HOLD : ST_T1;
      default: state_next = ST_HOLD;
    endcase
  end

  // Requests are only sampled on the edge that enters T1; a read wins a conflict.
  always_comb begin
    enter_t1 = (state_next == ST_T1);
    cyc_next = cyc_reg;
    if (enter_t1) begin
      if (ctl_mread)
        cyc_next = CYC_READ;
      else if (ctl_mwrite)
        cyc_next = CYC_WRITE;
      else
        cyc_next = CYC_NONE;
    end
  end

  // Pin values are computed for the state being entered, then registered.
  always_comb begin
    rd_n_next      = 1'b1;
    wr_n_next      = 1'b1;
    oe_next        = 1'b0;
    din_valid_next = 1'b0;
    m_start_next   = 1'b0;
    m_end_next     = 1'b0;
    t_phase_next   = 2'd0;
    case (state_next)
      ST_T1: begin
        t_phase_next = 2'd0;
        m_start_next = 1'b1;
        rd_n_next    = (cyc_next != CYC_READ);
      end
      ST_T2: begin
        t_phase_next = 2'd1;
        rd_n_next    = (cyc_next != CYC_READ);
        wr_n_next    = (cyc_next != CYC_WRITE);
        oe_next      = (cyc_next == CYC_WRITE);
      end
      ST_T3: begin
        t_phase_next = 2'd2;
        rd_n_next    = (cyc_next != CYC_READ);
        wr_n_next    = (cyc_next != CYC_WRITE);
        oe_next      = (cyc_next == CYC_WRITE);
      end
      ST_T4: begin
        t_phase_next   = 2'd3;
        m_end_next     = 1'b1;
        oe_next        = (cyc_next == CYC_WRITE);
        din_valid_next = (cyc_next == CYC_READ);
      end
      default: begin
        t_phase_next = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_HOLD;
      cyc_reg   <= CYC_NONE;
      a_pin     <= '0;
      d_pin_out <= '0;
      d_pin_oe  <= 1'b0;
      rd_n      <= 1'b1;
      wr_n      <= 1'b1;
      din       <= '0;
      din_valid <= 1'b0;
      t_phase   <= 2'd0;
      m_start   <= 1'b0;
      m_end     <= 1'b0;
      req_err   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cyc_reg   <= cyc_next;
      d_pin_oe  <= oe_next;
      rd_n      <= rd_n_next;
      wr_n      <= wr_n_next;
      din_valid <= din_valid_next;
      t_phase   <= t_phase_next;
      m_start   <= m_start_next;
      m_end     <= m_end_next;
      if (enter_t1) begin
        a_pin     <= apin;
        d_pin_out <= dout;
        if (ctl_mread && ctl_mwrite)
          req_err <= 1'b1;
      end
      // Read data is taken on the edge leaving T3 so it is on din throughout T4.
      if (state_reg == ST_T3 && cyc_reg == CYC_READ)
        din <= d_pin_in;
    end
  end

endmodule

// File: tb/tb_sm83_bus_ctl.sv
// Scoreboard bench for sm83_bus_ctl: the driver queues expected M-cycles, a negedge
// monitor pops one per m_start and checks every T-state and the idle cycles in between.
module tb_sm83_bus_ctl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] apin = '0;
  logic [7:0]  dout = '0;
  logic        ctl_mread = 1'b0;
  logic        ctl_mwrite = 1'b0;
  logic        ctl_hold = 1'b1;
  logic [7:0]  d_pin_in;
  logic [15:0] a_pin;
  logic [7:0]  d_pin_out;
  logic        d_pin_oe, rd_n, wr_n, din_valid, m_start, m_end, req_err;
  logic [7:0]  din;
  logic [1:0]  t_phase;

  sm83_bus_ctl #(.ADR_W(16), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .apin(apin), .dout(dout),
    .ctl_mread(ctl_mread), .ctl_mwrite(ctl_mwrite), .ctl_hold(ctl_hold),
    .d_pin_in(d_pin_in), .a_pin(a_pin), .d_pin_out(d_pin_out), .d_pin_oe(d_pin_oe),
    .rd_n(rd_n), .wr_n(wr_n), .din(din), .din_valid(din_valid), .t_phase(t_phase),
    .m_start(m_start), .m_end(m_end), .req_err(req_err)
  );

  always #5 clk = ~clk;

  // Memory model on the data pins
  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    if (a == 16'h1234) return 8'hA5;
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction
  always_comb d_pin_in = mem_rd(a_pin);

  localparam logic [1:0] K_NONE = 2'd0, K_READ = 2'd1, K_WRITE = 2'd2;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  wd;
    logic [1:0]  kind;
    logic [7:0]  din;
    logic        err;
    int          gap;
  } item_t;

  item_t sb[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_a_pin"}, 32'(a_pin), 32'h0);
    chk({tag, "_d_pin_out"}, 32'(d_pin_out), 32'h0);
    chk({tag, "_d_pin_oe"}, 32'(d_pin_oe), 32'h0);
    chk({tag, "_rd_n"}, 32'(rd_n), 32'h1);
    chk({tag, "_wr_n"}, 32'(wr_n), 32'h1);
    chk({tag, "_din"}, 32'(din), 32'h0);
    chk({tag, "_din_valid"}, 32'(din_valid), 32'h0);
    chk({tag, "_t_phase"}, 32'(t_phase), 32'h0);
    chk({tag, "_m_start"}, 32'(m_start), 32'h0);
    chk({tag, "_m_end"}, 32'(m_end), 32'h0);
    chk({tag, "_req_err"}, 32'(req_err), 32'h0);
  endtask

  // Drive one request, queue its expectation, and wait for its T1.
  task automatic issue(input logic [15:0] a, input logic [7:0] wd, input logic mr,
                       input logic mw, input logic [1:0] kind, input logic [7:0] exp_din,
                       input logic exp_err, input int gap);
    item_t it;
    logic seen;
    it.addr = a; it.wd = wd; it.kind = kind; it.din = exp_din; it.err = exp_err; it.gap = gap;
    sb.push_back(it);
    apin = a; dout = wd; ctl_mread = mr; ctl_mwrite = mw; ctl_hold = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (m_start) begin seen = 1'b1; break; end
    end
    chk("m_start_seen", 32'(seen), 32'h1);
  endtask

  // Monitor
  item_t       cur;
  logic        active = 1'b0;
  int          ph = 0;
  int          cyc_cnt = 0;
  int          last_end = -100;
  logic [15:0] last_addr = '0;
  logic [3:0]  rp, wp, op, dp;

  always @(negedge clk) begin
    cyc_cnt++;
    if (reset) begin
      active = 1'b0;
      last_end = -100;
      last_addr = '0;
    end else begin
      if (m_start) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("[TB] FAIL unexpected_m_start: got m_start=1 required no cycle at %0t", $time);
          active = 1'b0;
        end else begin
          cur = sb.pop_front();
          if (cur.gap >= 0) chk("gap", 32'(cyc_cnt - last_end - 1), 32'(cur.gap));
          active = 1'b1;
          ph = 0;
        end
      end else if (active) begin
        ph++;
      end
      if (active) begin
        rp = (cur.kind == K_READ)  ? 4'b1000 : 4'b1111;
        wp = (cur.kind == K_WRITE) ? 4'b1001 : 4'b1111;
        op = (cur.kind == K_WRITE) ? 4'b1110 : 4'b0000;
        dp = (cur.kind == K_READ)  ? 4'b1000 : 4'b0000;
        chk("t_phase", 32'(t_phase), 32'(ph));
        chk("m_start", 32'(m_start), 32'(ph == 0));
        chk("m_end", 32'(m_end), 32'(ph == 3));
        chk("a_pin", 32'(a_pin), 32'(cur.addr));
        chk("rd_n", 32'(rd_n), 32'(rp[ph]));
        chk("wr_n", 32'(wr_n), 32'(wp[ph]));
        chk("d_pin_oe", 32'(d_pin_oe), 32'(op[ph]));
        chk("din_valid", 32'(din_valid), 32'(dp[ph]));
        chk("req_err", 32'(req_err), 32'(cur.err));
        if (cur.kind == K_WRITE) chk("d_pin_out", 32'(d_pin_out), 32'(cur.wd));
        if (ph == 3) begin
          chk("din", 32'(din), 32'(cur.din));
          $display("[TB] mcycle addr=%h kind=%0d din=%h err=%0d", a_pin, cur.kind, din, req_err);
          active = 1'b0;
          last_end = cyc_cnt;
          last_addr = cur.addr;
        end
      end else begin
        chk("idle_rd_n", 32'(rd_n), 32'h1);
        chk("idle_wr_n", 32'(wr_n), 32'h1);
        chk("idle_oe", 32'(d_pin_oe), 32'h0);
        chk("idle_din_valid", 32'(din_valid), 32'h0);
        chk("idle_m_end", 32'(m_end), 32'h0);
        chk("idle_t_phase", 32'(t_phase), 32'h0);
        chk("idle_a_pin", 32'(a_pin), 32'(last_addr));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b1;
    #2 reset_checks("por");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // addr, wdata, mread, mwrite, kind, expected din, expected req_err, gap
    issue(16'h1234, 8'h00, 1'b1, 1'b0, K_READ,  8'hA5, 1'b0, -1);
    issue(16'hFF80, 8'h3C, 1'b0, 1'b1, K_WRITE, 8'hA5, 1'b0, 0);
    issue(16'h0100, 8'h00, 1'b1, 1'b0, K_READ,  8'h5B, 1'b0, 0);
    issue(16'h0101, 8'h77, 1'b0, 1'b1, K_WRITE, 8'h5B, 1'b0, 0);
    ctl_hold = 1'b1;
    repeat (8) @(posedge clk);
    #1 ctl_hold = 1'b0;
    issue(16'h2222, 8'h11, 1'b0, 1'b0, K_NONE,  8'h5B, 1'b0, 5);
    issue(16'hBEEF, 8'h00, 1'b1, 1'b0, K_READ,  8'h0B, 1'b0, 0);
    issue(16'h4321, 8'hEE, 1'b1, 1'b1, K_READ,  8'h38, 1'b1, 0);
    issue(16'h0055, 8'hC3, 1'b0, 1'b1, K_WRITE, 8'h38, 1'b1, 0);
    issue(16'h0AAA, 8'h99, 1'b0, 1'b1, K_WRITE, 8'h38, 1'b1, 0);
    ctl_hold = 1'b1;
    @(posedge clk);
    #2 reset = 1'b1;
    #1 reset_checks("midreset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    issue(16'h1234, 8'h00, 1'b1, 1'b0, K_READ,  8'hA5, 1'b0, -1);
    ctl_hold = 1'b1;
    repeat (10) @(posedge clk);
    #1 chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
